phys_reg_free_list: RTL
=======================

# phys_reg_free_list

Circular free list of physical register numbers for the rename stage. It supplies the new physical destination that rename writes into `reg_map_table` as `new_map_value`. Retirement returns released physical registers to it. A pipeline flush restores every speculatively allocated register in one cycle by rewinding the allocation pointer to the committed pointer.

## Interface
Parameters:
- `REG_FILE_ADDR_WIDTH`, 7, physical register number width.
- `NUM_PHYS_REGS`, 128, physical register count; must equal 2**`REG_FILE_ADDR_WIDTH`.
- `NUM_ARCH_REGS`, 32, architectural registers, identity-mapped at reset.

Ports (DEPTH = `NUM_PHYS_REGS` − `NUM_ARCH_REGS` = 96):
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `alloc_req`  in  1  rename consumes one free register this cycle.
- `alloc_valid`  out  1  list non-empty; `alloc_preg` is meaningful.
- `alloc_preg`  out  `REG_FILE_ADDR_WIDTH`  register at the speculative head.
- `commit_alloc`  in  1  oldest speculative allocation becomes non-speculative (instruction with rd != x0 retired).
- `free_valid`  in  1  push `free_preg` (previous mapping of a retired rd).
- `free_preg`  in  `REG_FILE_ADDR_WIDTH`  register being released.
- `flush`  in  1  discard all speculative allocations.
- `free_count`  out  7  registers currently available to allocate.
- `error`  out  1  sticky protocol-violation flag.

## Operation
- Storage is DEPTH entries. Pointers run 0..DEPTH−1 and wrap explicitly from DEPTH−1 to 0; DEPTH is not a power of two, so natural binary overflow is not used.
  - `spec_head`: next register to allocate.
  - `commit_head`: oldest non-committed allocation.
  - `tail`: next write slot.
- Reset: entry i = `NUM_ARCH_REGS` + i. `spec_head` = `commit_head` = 0, `tail` = 0, list full. Outputs at reset: `alloc_valid` = 1, `alloc_preg` = 32, `free_count` = 96, `error` = 0.
- Alloc: if `alloc_req` and `alloc_valid`, then `spec_head` advances. `alloc_req` with `alloc_valid` = 0 is ignored and sets `error`.
- Commit: `commit_head` advances. A commit when `commit_head` == `spec_head` (no outstanding allocation) is ignored and sets `error`.
- Free: `free_preg` is written at `tail` and `tail` advances. A free when the total occupancy (tail to `commit_head`) is already DEPTH is ignored and sets `error`. `free_preg` == 0 is ignored and sets `error`, because p0 backs x0 and is never recycled.
- Flush: `spec_head` ← `commit_head` after this cycle's commit is applied. `alloc_req` in the same cycle is ignored and does not set `error`.
- Simultaneous events in one cycle:
  - Alloc, commit and free are all applied.
  - A free never bypasses to `alloc_preg` in the same cycle; `alloc_valid` and `free_count` reflect registered state only.
- `free_count` = (`tail` − `spec_head`) mod DEPTH, with full-vs-empty disambiguated by a registered count. It is maintained as a counter: +1 on accepted free, −1 on accepted alloc, and set to committed occupancy + same-cycle free on flush.
- `error` is cleared only by reset.

## Timing
- `alloc_preg` and `alloc_valid` are combinational from registered pointers and storage, so rename uses them in the same cycle it asserts `alloc_req`. The pop takes effect at the next edge.
- A freed register is allocatable one cycle after `free_valid`, and is visible on `alloc_preg` only when it reaches the head.
- Flush: on the cycle after the flush edge, `alloc_preg` = entry at `commit_head` and `free_count` is restored.
- Asynchronous reset assertion mid-operation forces the reset state immediately, regardless of `clock`.

## Structure
- Shared rename package holds `REG_FILE_ADDR_WIDTH`, `NUM_ARCH_REGS`, `NUM_PHYS_REGS`, the derived `FREE_LIST_DEPTH` constant and the `preg_t` typedef. `reg_map_table` uses the same package.
- One sub-module is natural: `wrap_ptr`, a modulo-DEPTH incrementer with enable. It is instantiated three times, once per pointer.

## Test plan
- Reset, then 96 back-to-back allocs → `alloc_preg` sequence 32..127. After the last, `alloc_valid` = 0 and `free_count` = 0. A 97th `alloc_req` sets `error` = 1.
- After reset, alloc 3 (p32, p33, p34), commit 1, flush → next `alloc_preg` = 33 and `free_count` = 95.
- Reset, alloc 96, commit 96, free p40 → one cycle later `alloc_valid` = 1, `alloc_preg` = 40, `free_count` = 1.
- Empty list, same-cycle `alloc_req` and free p50 → alloc refused, `error` = 1. Next cycle `alloc_preg` = 50.
- Full list (reset state), `free_valid` with p45 → ignored, `error` = 1, `free_count` stays 96. In a fresh run, free p0 after one alloc and commit → ignored, `error` = 1.
- Wrap-around: 200 cycles of alloc + commit + free with recycled numbers → no `error`, `free_count` constant, returned order matches push order across the DEPTH−1 → 0 pointer wrap. Assert `reset` low mid-sequence → state returns to the reset values immediately.

Source files
------------

// File: rtl/phys_reg_free_list_pkg.sv
// Shared rename constants and types used by the physical register free list and map table.
package phys_reg_free_list_pkg;

  localparam int unsigned REG_FILE_ADDR_WIDTH = 7;
  localparam int unsigned NUM_PHYS_REGS       = 128;
  localparam int unsigned NUM_ARCH_REGS       = 32;
  localparam int unsigned FREE_LIST_DEPTH     = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int unsigned PTR_WIDTH           = $clog2(FREE_LIST_DEPTH);
  localparam int unsigned COUNT_WIDTH         = 7;

  typedef logic [REG_FILE_ADDR_WIDTH-1:0] preg_t;
  typedef logic [PTR_WIDTH-1:0]           ptr_t;
  typedef logic [COUNT_WIDTH-1:0]         count_t;

  // Depth is not a power of two, so the wrap back to zero is explicit.
  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == PTR_WIDTH'(FREE_LIST_DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  // Slot i initially holds the first non-architectural register plus i.
  function automatic preg_t reset_entry(int unsigned idx);
    return REG_FILE_ADDR_WIDTH'(NUM_ARCH_REGS + idx);
  endfunction

endpackage

// File: rtl/phys_reg_free_list_if.sv
// Rename/retire side handshake with the physical register free list.
interface phys_reg_free_list_if;
  import phys_reg_free_list_pkg::*;

  logic   alloc_req;
  logic   alloc_valid;
  preg_t  alloc_preg;
  logic   commit_alloc;
  logic   free_valid;
  preg_t  free_preg;
  logic   flush;
  count_t free_count;
  logic   error;

  modport master (
    output alloc_req, commit_alloc, free_valid, free_preg, flush,
    input  alloc_valid, alloc_preg, free_count, error
  );

  modport slave (
    input  alloc_req, commit_alloc, free_valid, free_preg, flush,
    output alloc_valid, alloc_preg, free_count, error
  );

endinterface

// File: rtl/phys_reg_free_list_wrap_ptr.sv
// Modulo-depth pointer register with increment enable and a load that takes priority.
module phys_reg_free_list_wrap_ptr
  import phys_reg_free_list_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic load,
  input  ptr_t load_val,
  output ptr_t ptr
);

  ptr_t ptr_d;

  always_comb begin
    ptr_d = ptr;
    if (load) begin
      ptr_d = load_val;
    end else if (en) begin
      ptr_d = ptr_inc(ptr);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_d;
    end
  end

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical registers with speculative/committed heads and one-cycle flush rewind.
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  phys_reg_free_list_if.slave  fl
);

  preg_t  mem [FREE_LIST_DEPTH];
  ptr_t   spec_head;
  ptr_t   commit_head;
  ptr_t   tail;
  ptr_t   flush_head;
  count_t free_cnt;
  count_t free_cnt_d;
  count_t occ_cnt;
  count_t occ_cnt_d;
  count_t outstanding;
  logic   error_q;
  logic   alloc_avail;
  logic   alloc_ok;
  logic   alloc_bad;
  logic   commit_ok;
  logic   commit_bad;
  logic   free_ok;
  logic   free_bad;

  assign alloc_avail    = (free_cnt != '0);
  assign outstanding    = occ_cnt - free_cnt;
  assign fl.alloc_valid = alloc_avail;
  assign fl.alloc_preg  = mem[spec_head];
  assign fl.free_count  = free_cnt;
  assign fl.error       = error_q;

  // Acceptance is judged on registered state only; a same-cycle free never feeds an alloc.
  always_comb begin
    alloc_ok   = fl.alloc_req && alloc_avail && !fl.flush;
    alloc_bad  = fl.alloc_req && !alloc_avail && !fl.flush;
    commit_ok  = fl.commit_alloc && (outstanding != '0);
    commit_bad = fl.commit_alloc && (outstanding == '0);
    free_ok    = fl.free_valid && (fl.free_preg != '0) &&
                 (occ_cnt != COUNT_WIDTH'(FREE_LIST_DEPTH));
    free_bad   = fl.free_valid && !free_ok;
    flush_head = commit_ok ? ptr_inc(commit_head) : commit_head;
  end

  always_comb begin
    occ_cnt_d  = occ_cnt;
    free_cnt_d = free_cnt;
    if (free_ok && !commit_ok) begin
      occ_cnt_d = occ_cnt + COUNT_WIDTH'(1);
    end else if (commit_ok && !free_ok) begin
      occ_cnt_d = occ_cnt - COUNT_WIDTH'(1);
    end
    // On flush every uncommitted allocation returns, leaving committed occupancy allocatable.
    if (fl.flush) begin
      free_cnt_d = occ_cnt_d;
    end else if (free_ok && !alloc_ok) begin
      free_cnt_d = free_cnt + COUNT_WIDTH'(1);
    end else if (alloc_ok && !free_ok) begin
      free_cnt_d = free_cnt - COUNT_WIDTH'(1);
    end
  end

  phys_reg_free_list_wrap_ptr u_spec_head (
    .clock    (clock),
    .reset    (reset),
    .en       (alloc_ok),
    .load     (fl.flush),
    .load_val (flush_head),
    .ptr      (spec_head)
  );

  phys_reg_free_list_wrap_ptr u_commit_head (
    .clock    (clock),
    .reset    (reset),
    .en       (commit_ok),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (commit_head)
  );

  phys_reg_free_list_wrap_ptr u_tail (
    .clock    (clock),
    .reset    (reset),
    .en       (free_ok),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (tail)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FREE_LIST_DEPTH; i++) begin
        mem[PTR_WIDTH'(i)] <= reset_entry(i);
      end
    end else if (free_ok) begin
      mem[tail] <= fl.free_preg;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      free_cnt <= COUNT_WIDTH'(FREE_LIST_DEPTH);
      occ_cnt  <= COUNT_WIDTH'(FREE_LIST_DEPTH);
      error_q  <= 1'b0;
    end else begin
      free_cnt <= free_cnt_d;
      occ_cnt  <= occ_cnt_d;
      error_q  <= error_q | alloc_bad | commit_bad | free_bad;
    end
  end

endmodule
